mem_port_arbiter: RTL and testbench

//  Shares one unified single-port memory between the IF stage (instruction fetch)
//  and the MEM stage (load/store). Sequences each access as a request/ack transaction.
//  - Drives the memory port.
//  - Returns read data to the winning stage.
//  - Raises per-stage stall signals so the pipeline freezes until its access completes.

---
 rtl/core_types_pkg.sv | 27 ++
 rtl/mem_port_prio.sv | 33 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: memory-port arbiter state and registered port bundle.
package core_types_pkg;

  localparam int unsigned CORE_ADDR_W = 32;
  localparam int unsigned CORE_DATA_W = 32;
  localparam int unsigned CORE_BE_W   = CORE_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_MEM
  } arb_state_t;

  typedef struct packed {
    logic                   en;
    logic                   we;
    logic [CORE_BE_W-1:0]   be;
    logic [CORE_ADDR_W-1:0] addr;
    logic [CORE_DATA_W-1:0] wdata;
  } arb_port_t;

  // Width of a counter that saturates at limit.
  function automatic int unsigned starve_cnt_w(int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_prio.sv
// Combinational grant decision for the IF/MEM memory port arbiter.
// FAIR_ARB_EN adds a starvation override in favour of IF.
module mem_port_prio
  import core_types_pkg::*;
`ifdef FAIR_ARB_EN
#(
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CNT_W = starve_cnt_w(STARVE_LIMIT)
)
`endif
(
  input  logic             if_req,
  input  logic             mem_req,
`ifdef FAIR_ARB_EN
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic             grant_if,
  output logic             grant_mem
);

  always_comb begin
    grant_mem = mem_req;
    grant_if  = if_req & ~mem_req;
`ifdef FAIR_ARB_EN
    // A starved fetch takes the port even against a pending load/store.
    if (if_req && mem_req && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
      grant_if  = 1'b1;
      grant_mem = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and MEM stages via request/ack.
// Build option FAIR_ARB_EN: IF is forced through after STARVE_LIMIT losses.
module mem_port_arbiter
  import core_types_pkg::*;
#(
  parameter int unsigned ADDR_W = CORE_ADDR_W,
  parameter int unsigned DATA_W = CORE_DATA_W
`ifdef FAIR_ARB_EN
  ,
  parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                port_en,
  output logic                port_we,
  output logic [DATA_W/8-1:0] port_be,
  output logic [ADDR_W-1:0]   port_addr,
  output logic [DATA_W-1:0]   port_wdata,
  input  logic [DATA_W-1:0]   port_rdata,
  input  logic                port_ready
);

  arb_state_t state;
  arb_port_t  port_q;
  logic       grant_if;
  logic       grant_mem;

`ifdef FAIR_ARB_EN
  localparam int unsigned CNT_W = starve_cnt_w(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt;

  mem_port_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .if_req     (if_req),
    .mem_req    (mem_req),
    .starve_cnt (starve_cnt),
    .grant_if   (grant_if),
    .grant_mem  (grant_mem)
  );
`else
  mem_port_prio u_prio (
    .if_req    (if_req),
    .mem_req   (mem_req),
    .grant_if  (grant_if),
    .grant_mem (grant_mem)
  );
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      port_q    <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
`ifdef FAIR_ARB_EN
      starve_cnt <= '0;
`endif
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_mem) begin
            state        <= GRANT_MEM;
            port_q.en    <= 1'b1;
            port_q.we    <= mem_we;
            port_q.be    <= mem_we ? mem_be : '1;
            port_q.addr  <= mem_addr;
            port_q.wdata <= mem_wdata;
          end else if (grant_if) begin
            state        <= GRANT_IF;
            port_q.en    <= 1'b1;
            port_q.we    <= 1'b0;
            port_q.be    <= '1;
            port_q.addr  <= if_addr;
            port_q.wdata <= '0;
          end
`ifdef FAIR_ARB_EN
          if (grant_if)
            starve_cnt <= '0;
          else if (grant_mem && if_req && (starve_cnt != CNT_W'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + 1'b1;
`endif
        end
        GRANT_IF: begin
          if (port_ready) begin
            state     <= IDLE;
            port_q.en <= 1'b0;
            if_rdata  <= port_rdata;
            if_ack    <= 1'b1;
          end
        end
        GRANT_MEM: begin
          if (port_ready) begin
            state     <= IDLE;
            port_q.en <= 1'b0;
            if (!port_q.we)
              mem_rdata <= port_rdata;
            mem_ack   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign port_en    = port_q.en;
  assign port_we    = port_q.we;
  assign port_be    = port_q.be;
  assign port_addr  = port_q.addr;
  assign port_wdata = port_q.wdata;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default or FAIR_ARB_EN build).
module tb_mem_port_arbiter;

  logic        Clock;
  logic        nReset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        port_en;
  logic        port_we;
  logic [3:0]  port_be;
  logic [31:0] port_addr;
  logic [31:0] port_wdata;
  logic [31:0] port_rdata;
  logic        port_ready;

  int unsigned num_checks = 0;
  int unsigned num_errors = 0;

  mem_port_arbiter dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .port_en    (port_en),
    .port_we    (port_we),
    .port_be    (port_be),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_rdata (port_rdata),
    .port_ready (port_ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  logic grant_is_if [10];
  int unsigned n_grants;

  initial begin
    nReset = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_be = '0; mem_addr = '0; mem_wdata = '0; port_rdata = '0; port_ready = 1'b0;

    // Reset state
    tick(); tick();
    check_val("rst_port_en", port_en, 0);
    check_val("rst_acks", {if_ack, mem_ack}, 0);
    check_val("rst_rdata", {if_rdata, mem_rdata}, 0);
    check_val("rst_port_addr", port_addr, 0);
    nReset = 1'b1;
    tick();

    // 1: single fetch, ready on first port_en cycle
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    check_val("t1_port", {port_en, port_we, port_be, port_addr}, {1'b1, 1'b0, 4'hF, 32'h40});
    check_val("t1_no_ack_yet", if_ack, 0);
    port_ready = 1'b1; port_rdata = 32'h00A00093;
    tick();
    port_ready = 1'b0;
    check_val("t1_if_ack", if_ack, 1);
    check_val("t1_if_rdata", if_rdata, 32'h00A00093);
    check_val("t1_stall_if", stall_if, 0);
    if_req = 1'b0;
    tick();
    check_val("t1_ack_pulse", if_ack, 0);

    // port_ready while idle is ignored
    port_ready = 1'b1; port_rdata = 32'hFFFF_FFFF;
    tick();
    port_ready = 1'b0;
    tick();
    check_val("idle_ready_acks", {if_ack, mem_ack, port_en}, 0);
    check_val("idle_ready_rdata", if_rdata, 32'h00A00093);

    // 2: simultaneous requests, MEM wins, bubble, then IF
    if_req = 1'b1; if_addr = 32'h44;
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'h0; mem_addr = 32'h100;
    tick();
    check_val("t2_mem_grant", {port_en, port_we, port_be, port_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
    check_val("t2_stalls", {stall_if, stall_mem}, 2'b11);
    port_ready = 1'b1; port_rdata = 32'h11223344;
    tick();
    port_ready = 1'b0;
    check_val("t2_mem_ack", {mem_ack, if_ack}, 2'b10);
    check_val("t2_mem_rdata", mem_rdata, 32'h11223344);
    check_val("t2_bubble", {port_en, stall_if}, 2'b01);
    mem_req = 1'b0;
    tick();
    check_val("t2_if_grant", {port_en, port_addr}, {1'b1, 32'h44});
    check_val("t2_stall_if", stall_if, 1);
    port_ready = 1'b1; port_rdata = 32'h55;
    tick();
    port_ready = 1'b0;
    check_val("t2_if_ack", {if_ack, if_rdata}, {1'b1, 32'h55});
    if_req = 1'b0;
    tick();

    // 3: store with port_ready delayed, controls held stable
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_val("t3_port_stable", {port_en, port_we, port_be, port_addr, port_wdata},
                {1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEADBEEF});
      check_val("t3_no_ack", mem_ack, 0);
      if (i == 3) begin
        port_ready = 1'b1; port_rdata = 32'h99999999;
      end
      tick();
    end
    port_ready = 1'b0;
    check_val("t3_mem_ack", mem_ack, 1);
    check_val("t3_mem_rdata_kept", mem_rdata, 32'h11223344);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    check_val("t3_ack_pulse", {mem_ack, port_en}, 0);

    // 6: fetch request dropped mid-transaction still completes
    if_req = 1'b1; if_addr = 32'h80;
    tick();
    if_req = 1'b0;
    check_val("t6_grant", {port_en, port_addr}, {1'b1, 32'h80});
    tick();
    check_val("t6_held", {port_en, stall_if}, 2'b10);
    port_ready = 1'b1; port_rdata = 32'h13;
    tick();
    port_ready = 1'b0;
    check_val("t6_if_ack", {if_ack, if_rdata}, {1'b1, 32'h13});
    tick();
    check_val("t6_idle", {if_ack, port_en}, 0);

    // 4: reset while GRANT_MEM waits on port_ready
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
    tick();
    check_val("t4_grant", {port_en, port_addr}, {1'b1, 32'h300});
    tick();
    #2 nReset = 1'b0;
    #1;
    check_val("t4_async_drop", {port_en, mem_ack}, 0);
    mem_req = 1'b0;
    tick();
    nReset = 1'b1;
    tick(); tick();
    check_val("t4_no_ack", {mem_ack, if_ack, port_en}, 0);
    mem_req = 1'b1; mem_addr = 32'h304;
    tick();
    check_val("t4_after_grant", {port_en, port_addr}, {1'b1, 32'h304});
    port_ready = 1'b1; port_rdata = 32'hCAFE;
    tick();
    port_ready = 1'b0;
    check_val("t4_after_ack", {mem_ack, mem_rdata}, {1'b1, 32'hCAFE});
    mem_req = 1'b0;
    tick();

    // 5: both requests held continuously from a fresh reset
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    if_req = 1'b1; if_addr = 32'h80;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 10; c++) begin
      tick();
      if (port_en && !port_ready) begin
        grant_is_if[n_grants] = (port_addr == 32'h80);
        n_grants++;
        port_ready = 1'b1;
      end else begin
        if (port_en)
          check_val("t5_back_to_back", port_en, 0);
        port_ready = 1'b0;
      end
    end
    port_ready = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    check_val("t5_grant_count", n_grants, 10);
    for (int g = 0; g < 10; g++) begin
`ifdef FAIR_ARB_EN
      check_val("t5_grant_order", grant_is_if[g], (g == 4 || g == 9) ? 1 : 0);
`else
      check_val("t5_grant_order", grant_is_if[g], 0);
`endif
    end
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
